// File: rtl/ex_mul.sv
// Iterative 32x32 multiply unit for the execute stage (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL).
// Four 32x8 partial-product steps, one sign-fix/accumulate step, then a one-cycle done pulse.
module ex_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_long,
   input  logic        i_signed,
   input  logic        i_acc,
   input  logic [31:0] i_rm,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_acc_lo,
   input  logic [31:0] i_acc_hi,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_res_lo,
   output logic [31:0] o_res_hi,
   output logic        o_n,
   output logic        o_z
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   logic [1:0]  state_q,  state_d;
   logic [1:0]  cnt_q,    cnt_d;
   logic [63:0] prod_q,   prod_d;
   logic [31:0] a_q,      a_d;
   logic [31:0] b_q,      b_d;
   logic        neg_q,    neg_d;
   logic        long_q,   long_d;
   logic        acc_q,    acc_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic        n_q,      n_d;
   logic        z_q,      z_d;
   logic        done_q,   done_d;

   logic [7:0]  byte_s;
   logic [39:0] pp_s;
   logic [63:0] pp_shift_s;
   logic [63:0] signed_prod_s;
   logic [63:0] fix_s;

   // Magnitude of a 32-bit operand; 0x80000000 maps to itself as an unsigned value.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic take_abs);
      if (take_abs && v[31]) begin
         return 32'd0 - v;
      end else begin
         return v;
      end
   endfunction

   // Partial product of the current multiplier byte and the final sign-fix/accumulate value.
   always_comb begin
      byte_s        = b_q[{cnt_q, 3'b000} +: 8];
      pp_s          = {8'd0, a_q} * {32'd0, byte_s};
      pp_shift_s    = {24'd0, pp_s} << {cnt_q, 3'b000};
      signed_prod_s = neg_q ? (64'd0 - prod_q) : prod_q;
      if (acc_q) begin
         fix_s = signed_prod_s + {acc_hi_q, acc_lo_q};
      end else begin
         fix_s = signed_prod_s;
      end
   end

   // Next-state logic; a flush returns to IDLE and leaves the result registers untouched.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      a_d      = a_q;
      b_d      = b_q;
      neg_d    = neg_q;
      long_d   = long_q;
      acc_d    = acc_q;
      acc_lo_d = acc_lo_q;
      acc_hi_d = acc_hi_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      n_d      = n_q;
      z_d      = z_q;
      done_d   = 1'b0;
      if (i_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  long_d   = i_long;
                  acc_d    = i_acc;
                  acc_lo_d = i_acc_lo;
                  // High accumulate word only contributes to long results.
                  acc_hi_d = i_long ? i_acc_hi : 32'd0;
                  a_d      = mag32(i_rm, i_long & i_signed);
                  b_d      = mag32(i_rs, i_long & i_signed);
                  neg_d    = i_long & i_signed & (i_rm[31] ^ i_rs[31]);
                  prod_d   = 64'd0;
                  cnt_d    = 2'd0;
                  state_d  = ST_MUL;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               prod_d = prod_q + pp_shift_s;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_MUL;
               end
            end
            ST_FIX: begin
               res_lo_d = fix_s[31:0];
               res_hi_d = long_q ? fix_s[63:32] : 32'd0;
               n_d      = long_q ? fix_s[63] : fix_s[31];
               z_d      = long_q ? (fix_s == 64'd0) : (fix_s[31:0] == 32'd0);
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 2'd0;
         prod_q   <= 64'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         neg_q    <= 1'b0;
         long_q   <= 1'b0;
         acc_q    <= 1'b0;
         acc_lo_q <= 32'd0;
         acc_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         res_hi_q <= 32'd0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         a_q      <= a_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         long_q   <= long_d;
         acc_q    <= acc_d;
         acc_lo_q <= acc_lo_d;
         acc_hi_q <= acc_hi_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         n_q      <= n_d;
         z_q      <= z_d;
         done_q   <= done_d;
      end
   end

   assign o_busy   = (state_q != ST_IDLE);
   assign o_done   = done_q;
   assign o_res_lo = res_lo_q;
   assign o_res_hi = res_hi_q;
   assign o_n      = n_q;
   assign o_z      = z_q;

endmodule

// File: tb/tb_ex_mul.sv
// Self-checking bench for ex_mul: directed test-plan vectors, flush/reset/collision
// scenarios and random operations checked against a plain 64-bit arithmetic model.
module tb_ex_mul;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_long;
   logic        i_signed;
   logic        i_acc;
   logic [31:0] i_rm;
   logic [31:0] i_rs;
   logic [31:0] i_acc_lo;
   logic [31:0] i_acc_hi;
   logic        i_flush;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_res_lo;
   logic [31:0] o_res_hi;
   logic        o_n;
   logic        o_z;

   int total = 0;
   int bad   = 0;

   logic [31:0] last_lo;
   logic [31:0] last_hi;
   logic        last_n;
   logic        last_z;

   ex_mul dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_long   (i_long),
      .i_signed (i_signed),
      .i_acc    (i_acc),
      .i_rm     (i_rm),
      .i_rs     (i_rs),
      .i_acc_lo (i_acc_lo),
      .i_acc_hi (i_acc_hi),
      .i_flush  (i_flush),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_res_lo (o_res_lo),
      .o_res_hi (o_res_hi),
      .o_n      (o_n),
      .o_z      (o_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: the full 64-bit architectural result (high word forced to 0 for short ops).
   function automatic logic [63:0] ref_r(input logic lng, input logic sgn, input logic acc,
                                         input logic [31:0] rm, input logic [31:0] rs,
                                         input logic [31:0] alo, input logic [31:0] ahi);
      logic [63:0] p;
      logic [63:0] x;
      logic [63:0] y;
      if (lng && sgn) begin
         x = {{32{rm[31]}}, rm};
         y = {{32{rs[31]}}, rs};
         p = $signed(x) * $signed(y);
      end else begin
         p = {32'd0, rm} * {32'd0, rs};
      end
      if (acc) p = p + {(lng ? ahi : 32'd0), alo};
      if (!lng) p = {32'd0, p[31:0]};
      return p;
   endfunction

   task automatic check_outputs(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                                input logic n, input logic z);
      chk({tag, ".lo"}, {32'd0, o_res_lo}, {32'd0, lo});
      chk({tag, ".hi"}, {32'd0, o_res_hi}, {32'd0, hi});
      chk({tag, ".n"},  {63'd0, o_n},      {63'd0, n});
      chk({tag, ".z"},  {63'd0, o_z},      {63'd0, z});
   endtask

   task automatic run_op(input string tag, input logic lng, input logic sgn, input logic acc,
                         input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] alo, input logic [31:0] ahi,
                         input logic interfere);
      logic [63:0] r;
      logic        en;
      logic        ez;
      r  = ref_r(lng, sgn, acc, rm, rs, alo, ahi);
      en = lng ? r[63] : r[31];
      ez = lng ? (r == 64'd0) : (r[31:0] == 32'd0);
      i_long = lng; i_signed = sgn; i_acc = acc;
      i_rm = rm; i_rs = rs; i_acc_lo = alo; i_acc_hi = ahi;
      i_start = 1'b1;
      @(posedge clk); #1;
      // Inputs are only sampled at acceptance; scramble them afterwards.
      i_start = interfere; i_long = 1'($urandom); i_signed = 1'($urandom); i_acc = 1'($urandom);
      i_rm = $urandom; i_rs = $urandom; i_acc_lo = $urandom; i_acc_hi = $urandom;
      chk({tag, ".busy0"}, {63'd0, o_busy}, 64'd1);
      chk({tag, ".done0"}, {63'd0, o_done}, 64'd0);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         i_start = 1'b0;
         if (k < 5) begin
            chk({tag, ".busy"}, {63'd0, o_busy}, 64'd1);
            chk({tag, ".done_early"}, {63'd0, o_done}, 64'd0);
         end else begin
            chk({tag, ".done"}, {63'd0, o_done}, 64'd1);
            chk({tag, ".busy_done"}, {63'd0, o_busy}, 64'd0);
            check_outputs(tag, r[31:0], r[63:32], en, ez);
         end
      end
      @(posedge clk); #1;
      chk({tag, ".done_once"}, {63'd0, o_done}, 64'd0);
      chk({tag, ".idle_after"}, {63'd0, o_busy}, 64'd0);
      check_outputs({tag, ".hold"}, r[31:0], r[63:32], en, ez);
      last_lo = r[31:0]; last_hi = r[63:32]; last_n = en; last_z = ez;
   endtask

   initial begin
      logic [31:0] rv;
      logic [31:0] sv;
      rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_long = 1'b0; i_signed = 1'b0; i_acc = 1'b0;
      i_rm = 32'd0; i_rs = 32'd0; i_acc_lo = 32'd0; i_acc_hi = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", {63'd0, o_busy}, 64'd0);
      chk("rst.done", {63'd0, o_done}, 64'd0);
      check_outputs("rst", 32'd0, 32'd0, 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("mul7x6", 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0);
      chk("mul7x6.const", {32'd0, last_lo}, 64'd42);
      run_op("umull_ff", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0);
      chk("umull_ff.const", {last_hi, last_lo}, 64'hFFFFFFFE_00000001);
      run_op("smull_min", 1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 1'b0);
      chk("smull_min.const", {last_hi, last_lo}, 64'h40000000_00000000);
      run_op("smull_m2x3", 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0);
      chk("smull_m2x3.const", {last_hi, last_lo}, 64'hFFFFFFFF_FFFFFFFA);
      run_op("smlal_zero", 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 32'd3, 32'd6, 32'd0, 1'b0);
      chk("smlal_zero.z", {63'd0, last_z}, 64'd1);
      run_op("mla_wrap", 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 1'b0);
      chk("mla_wrap.z", {63'd0, last_z}, 64'd1);
      run_op("umlal", 1'b1, 1'b0, 1'b1, 32'd2, 32'd3, 32'hFFFFFFFF, 32'd1, 1'b0);
      chk("umlal.const", {last_hi, last_lo}, 64'h00000002_00000005);
      run_op("short_sgn_ign", 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'd3, 32'd10, 32'h12345678, 1'b0);

      // Flush during MUL: abort with no done and results held.
      i_long = 1'b1; i_signed = 1'b0; i_acc = 1'b0; i_rm = 32'd1234; i_rs = 32'd5678;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      chk("flush.busy", {63'd0, o_busy}, 64'd0);
      for (int k = 0; k < 6; k++) begin
         chk("flush.no_done", {63'd0, o_done}, 64'd0);
         @(posedge clk); #1;
      end
      check_outputs("flush.hold", last_lo, last_hi, last_n, last_z);
      run_op("after_flush", 1'b0, 1'b0, 1'b0, 32'd4, 32'd5, 32'd0, 32'd0, 1'b0);
      chk("after_flush.const", {32'd0, last_lo}, 64'd20);

      // Start and flush together: not accepted.
      i_rm = 32'd9; i_rs = 32'd9; i_start = 1'b1; i_flush = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_flush = 1'b0;
      chk("startflush.busy", {63'd0, o_busy}, 64'd0);
      for (int k = 0; k < 6; k++) begin
         chk("startflush.no_done", {63'd0, o_done}, 64'd0);
         @(posedge clk); #1;
      end
      check_outputs("startflush.hold", last_lo, last_hi, last_n, last_z);

      // Second start while busy is ignored.
      run_op("busy_start", 1'b0, 1'b0, 1'b1, 32'd100, 32'd3, 32'd11, 32'd0, 1'b1);

      // Random operations.
      for (int t = 0; t < 40; t++) begin
         rv = $urandom; sv = $urandom;
         if ((t % 5) == 1) rv = 32'h80000000;
         if ((t % 7) == 2) sv = 32'hFFFFFFFF;
         if ((t % 9) == 3) rv = 32'd0;
         run_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), rv, sv, $urandom, $urandom, 1'($urandom));
      end

      // Reset during FIX: everything cleared, no done.
      i_long = 1'b0; i_signed = 1'b0; i_acc = 1'b0; i_rm = 32'd7; i_rs = 32'd6;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rstfix.busy_pre", {63'd0, o_busy}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstfix.busy", {63'd0, o_busy}, 64'd0);
      chk("rstfix.done", {63'd0, o_done}, 64'd0);
      check_outputs("rstfix", 32'd0, 32'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("rstfix.done_next", {63'd0, o_done}, 64'd0);
      check_outputs("rstfix.next", 32'd0, 32'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
